// File: rtl/dot_product_vector_feeder.sv
// Operand-vector buffers and chunk streamer for the bfloat16 dot-product MLP stack.
// Replays both buffers with first/last framing and tracks results owed by the macro.
module dot_product_vector_feeder #(
    parameter int K     = 4,
    parameter int B     = 2,
    parameter int FP    = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [K*B*FP-1:0] i_wr_a,
    input  logic [K*B*FP-1:0] i_wr_b,
    input  logic              i_start,
    input  logic [LW-1:0]     i_len,
    output logic              o_busy,
    output logic [K*B*FP-1:0] o_a,
    output logic [K*B*FP-1:0] o_b,
    output logic              o_first,
    output logic              o_last,
    input  logic              i_valid,
    output logic [3:0]        o_pending,
    output logic              o_err
);
    localparam int W = K * B * FP;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]   len_q, len_d;
    logic [3:0]      pending_q, pending_d;

    logic [W-1:0]    mem_a [DEPTH];
    logic [W-1:0]    mem_b [DEPTH];
    logic [W-1:0]    rd_a_q, rd_b_q;
    logic            rd_vld_q, rd_first_q, rd_last_q;

    logic [W-1:0]    a_q, b_q;
    logic            first_q, last_q, busy_q, err_q;

    logic            reading, at_end, len_ok, cmd_bad, valid_bad;

    // Result bookkeeping: a result is owed from the cycle o_last leaves, repaid by i_valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        pending_d = pending_q;
        valid_bad = 1'b0;
        if (last_q && !i_valid) begin
            if (pending_q != 4'hF) pending_d = pending_q + 4'd1;
        end else if (i_valid && !last_q) begin
            if (pending_q == 4'd0) valid_bad = 1'b1;
            else                   pending_d = pending_q - 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        cmd_bad = 1'b0;
        reading = 1'b0;
        at_end  = (LW'(cnt_q) == len_q - LW'(1));
        len_ok  = (i_len != '0) && (i_len <= LW'(DEPTH));
        case (state_q)
            S_IDLE: begin
                // Check the count as it will stand after this edge so a result landing now still counts.
                if (i_start) begin
                    if (len_ok && pending_d != 4'hF) begin
                        state_d = S_RUN;
                        len_d   = i_len;
                        cnt_d   = '0;
                    end else begin
                        cmd_bad = 1'b1;
                    end
                end
            end
            S_RUN: begin
                reading = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (at_end) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: buffer storage and its read register carry no reset; contents must survive i_reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_a[i_wr_addr] <= i_wr_a;
            mem_b[i_wr_addr] <= i_wr_b;
        end
        rd_a_q <= mem_a[cnt_q];
        rd_b_q <= mem_b[cnt_q];
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            pending_q  <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            rd_last_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            pending_q  <= pending_d;
            rd_vld_q   <= reading;
            rd_first_q <= reading && (cnt_q == '0);
            rd_last_q  <= reading && at_end;
            // Idle cycles present zeros so the accumulator never sees stale chunks.
            a_q        <= rd_vld_q ? rd_a_q : '0;
            b_q        <= rd_vld_q ? rd_b_q : '0;
            first_q    <= rd_first_q;
            last_q     <= rd_last_q;
            busy_q     <= (state_q != S_IDLE);
            err_q      <= cmd_bad | valid_bad;
        end
    end

    assign o_a       = a_q;
    assign o_b       = b_q;
    assign o_first   = first_q;
    assign o_last    = last_q;
    assign o_busy    = busy_q;
    assign o_err     = err_q;
    assign o_pending = pending_q;

endmodule

// File: tb/tb_dot_product_vector_feeder.sv
// Directed bench for dot_product_vector_feeder: a scoreboard of expected chunks, error
// pulses and outstanding-result count is checked every cycle alongside directed spot checks.
module tb_dot_product_vector_feeder;
    localparam int K     = 4;
    localparam int B     = 2;
    localparam int FP    = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int LW    = 7;
    localparam int W     = K * B * FP;
    localparam int CW    = 2 * W + 8;

    logic            clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_wr_en = 1'b0;
    logic [AW-1:0]   i_wr_addr = '0;
    logic [W-1:0]    i_wr_a = '0;
    logic [W-1:0]    i_wr_b = '0;
    logic            i_start = 1'b0;
    logic [LW-1:0]   i_len = '0;
    logic            i_valid = 1'b0;
    logic            o_busy, o_first, o_last, o_err;
    logic [W-1:0]    o_a, o_b;
    logic [3:0]      o_pending;

    dot_product_vector_feeder #(.K(K), .B(B), .FP(FP), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr), .i_wr_a(i_wr_a), .i_wr_b(i_wr_b),
        .i_start(i_start), .i_len(i_len), .o_busy(o_busy),
        .o_a(o_a), .o_b(o_b), .o_first(o_first), .o_last(o_last),
        .i_valid(i_valid), .o_pending(o_pending), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int           cyc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         first;
        logic         last;
    } exp_t;

    exp_t         sb[$];
    int           err_cyc[$];
    logic [W-1:0] model_a [DEPTH];
    logic [W-1:0] model_b [DEPTH];
    int           exp_pend = 0;
    logic         last_prev = 1'b0;
    int           checks = 0;
    int           passed = 0;
    int           fails  = 0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs 1 time unit after each rising edge, when the edge's results are stable.
    task automatic mon_step();
        exp_t         e;
        logic [W-1:0] ea, eb;
        logic         ef, el, cmd_err, val_err;
        ea = '0; eb = '0; ef = 1'b0; el = 1'b0; cmd_err = 1'b0; val_err = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e  = sb.pop_front();
            ea = e.a; eb = e.b; ef = e.first; el = e.last;
        end
        if (err_cyc.size() > 0 && err_cyc[0] == cyc) begin
            void'(err_cyc.pop_front());
            cmd_err = 1'b1;
        end
        if (i_reset) begin
            exp_pend = 0;
        end else if (last_prev && !i_valid) begin
            if (exp_pend < 15) exp_pend++;
        end else if (i_valid && !last_prev) begin
            if (exp_pend == 0) val_err = 1'b1;
            else               exp_pend--;
        end
        check($sformatf("stream@%0d", cyc), CW'({o_a, o_b, o_first, o_last}), CW'({ea, eb, ef, el}));
        check($sformatf("err@%0d", cyc), CW'(o_err), CW'(cmd_err | val_err));
        check($sformatf("pending@%0d", cyc), CW'(o_pending), CW'(exp_pend));
        last_prev = el;
    endtask

    always @(posedge clk) begin
        #1;
        mon_step();
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_neg(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Drives one start strobe; returns on the falling edge after acceptance edge t.
    task automatic start_cmd(input int n, input bit ok, output int t);
        exp_t e;
        @(negedge clk);
        i_start = 1'b1;
        i_len   = LW'(n);
        t       = cyc + 1;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                e.cyc = t + 2 + i; e.a = model_a[i]; e.b = model_b[i];
                e.first = (i == 0); e.last = (i == n - 1);
                sb.push_back(e);
            end
        end else begin
            err_cyc.push_back(t);
        end
        @(negedge clk);
        i_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t, t16;
        logic [W-1:0] va, vb;

        // Reset state
        wait_cyc(2);
        check("rst_busy", CW'(o_busy), CW'(0));
        check("rst_outs", CW'({o_a, o_b, o_first, o_last, o_err}), CW'(0));
        check("rst_pending", CW'(o_pending), CW'(0));
        go_neg(2);
        i_reset = 1'b0;

        // Load: A lanes carry {address, lane}; B is 1.0 for the first four chunks
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < K * B; j++) begin
                va[j*FP +: FP] = {i[7:0], j[7:0]};
                vb[j*FP +: FP] = (i < 4) ? 16'h3F80 : 16'($urandom);
            end
            @(negedge clk);
            i_wr_en = 1'b1; i_wr_addr = AW'(i); i_wr_a = va; i_wr_b = vb;
            model_a[i] = va; model_b[i] = vb;
        end
        @(negedge clk);
        i_wr_en = 1'b0;

        // len=4, with a same-address write colliding with the read of chunk 2
        start_cmd(4, 1'b1, t);
        wait_cyc(t + 1); check("len4_busy_t1", CW'(o_busy), CW'(1));
        wait_cyc(t + 2); check("len4_first", CW'({o_first, o_last}), CW'(2'b10));
        go_neg(t + 2);
        i_wr_en = 1'b1; i_wr_addr = AW'(2); i_wr_a = ~model_a[2]; i_wr_b = model_b[2];
        model_a[2] = ~model_a[2];
        go_neg(t + 3);
        i_wr_en = 1'b0;
        wait_cyc(t + 5);
        check("len4_last", CW'({o_first, o_last}), CW'(2'b01));
        check("len4_busy_t5", CW'(o_busy), CW'(1));
        wait_cyc(t + 6);
        check("len4_busy_t6", CW'(o_busy), CW'(0));
        check("len4_pending", CW'(o_pending), CW'(1));
        go_neg(t + 6); i_valid = 1'b1;
        go_neg(t + 7); i_valid = 1'b0;
        wait_cyc(t + 8); check("len4_returned", CW'(o_pending), CW'(0));

        // len=1
        start_cmd(1, 1'b1, t);
        wait_cyc(t + 1); check("len1_busy_t1", CW'(o_busy), CW'(1));
        wait_cyc(t + 2);
        check("len1_busy_t2", CW'(o_busy), CW'(1));
        check("len1_flags", CW'({o_first, o_last}), CW'(2'b11));
        wait_cyc(t + 3); check("len1_busy_t3", CW'(o_busy), CW'(0));
        go_neg(t + 3); i_valid = 1'b1;
        go_neg(t + 4); i_valid = 1'b0;

        // len=DEPTH, then the illegal lengths 0 and DEPTH+1
        start_cmd(DEPTH, 1'b1, t);
        wait_cyc(t + DEPTH + 1); check("len64_last", CW'({o_first, o_last}), CW'(2'b01));
        wait_cyc(t + DEPTH + 2); check("len64_busy_end", CW'(o_busy), CW'(0));
        go_neg(t + DEPTH + 2); i_valid = 1'b1;
        go_neg(t + DEPTH + 3); i_valid = 1'b0;
        start_cmd(0, 1'b0, t);
        wait_cyc(t); check("len0_err", CW'(o_err), CW'(1));
        wait_cyc(t + 1); check("len0_idle", CW'(o_busy), CW'(0));
        start_cmd(DEPTH + 1, 1'b0, t);
        wait_cyc(t); check("len65_err", CW'(o_err), CW'(1));
        wait_cyc(t + 1); check("len65_idle", CW'(o_busy), CW'(0));

        // Fill the outstanding count to 15, then a start must be refused
        for (int k = 0; k < 15; k++) begin
            start_cmd(2, 1'b1, t);
            go_neg(t + 2);
        end
        wait_cyc(t + 4); check("pend_full", CW'(o_pending), CW'(15));
        go_neg(t + 4);
        start_cmd(2, 1'b0, t16);
        wait_cyc(t16); check("full_reject_err", CW'(o_err), CW'(1));
        wait_cyc(t16 + 1);
        check("full_reject_idle", CW'(o_busy), CW'(0));
        check("full_reject_pend", CW'(o_pending), CW'(15));
        go_neg(t16 + 1); i_valid = 1'b1;
        go_neg(t16 + 2); i_valid = 1'b0;
        wait_cyc(t16 + 3); check("pend_14", CW'(o_pending), CW'(14));

        // i_valid coincident with o_last holds the count, then drain past zero
        start_cmd(2, 1'b1, t);
        go_neg(t + 3);
        i_valid = 1'b1;
        wait_cyc(t + 3); check("coinc_last", CW'(o_last), CW'(1));
        wait_cyc(t + 4); check("coinc_hold", CW'(o_pending), CW'(14));
        wait_cyc(t + 18);
        check("drain_zero", CW'(o_pending), CW'(0));
        check("drain_no_err", CW'(o_err), CW'(0));
        wait_cyc(t + 19);
        check("under_err", CW'(o_err), CW'(1));
        check("under_pend", CW'(o_pending), CW'(0));
        go_neg(t + 19); i_valid = 1'b0;

        // Reset at chunk 3 of a len=8 vector, with one result outstanding
        start_cmd(1, 1'b1, t);
        go_neg(t + 2);
        start_cmd(8, 1'b1, t);
        go_neg(t + 5);
        i_reset = 1'b1;
        sb.delete();
        wait_cyc(t + 6);
        check("midrst_busy", CW'(o_busy), CW'(0));
        check("midrst_pend", CW'(o_pending), CW'(0));
        check("midrst_outs", CW'({o_a, o_b, o_first, o_last}), CW'(0));
        go_neg(t + 6);
        i_reset = 1'b0;

        // Buffers survive reset
        start_cmd(2, 1'b1, t);
        wait_cyc(t + 4); check("post_rst_busy", CW'(o_busy), CW'(0));
        wait_cyc(t + 6);
        check("sb_drained", CW'(sb.size() + err_cyc.size()), CW'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
